// File: rtl/rps_match_scorer.sv
// Purpose: samples the RPS judge code on round commit, keeps scores/draws, holds results, declares match winner.
// Latency: every output is registered; a committed round shows on the outputs one cycle after the round_start edge.
// Backpressure: none; round_start is dropped while busy (SHOW or MATCH_OVER), and new_match is always accepted.
module rps_match_scorer #(
    parameter int WIN_TARGET  = 3,
    parameter int SHOW_CYCLES = 25_000_000,
    parameter int SCORE_W     = 4,
    parameter int SHOW_W      = 25
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_round_start,
    input  logic               i_new_match,
    input  logic [2:0]         i_winner_in,
    output logic [2:0]         o_result_led,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic [SCORE_W-1:0] o_draws,
    output logic               o_match_over,
    output logic               o_busy,
    output logic               o_invalid_round
);

    // One-hot judge codes; anything else on a commit counts as an invalid round.
    localparam logic [2:0] CODE_NONE = 3'b000;
    localparam logic [2:0] CODE_P1   = 3'b100;
    localparam logic [2:0] CODE_DRAW = 3'b010;
    localparam logic [2:0] CODE_P2   = 3'b001;

    // The timer is loaded with SHOW_CYCLES-1 and expires on reaching zero,
    // so a round result stays on the light for exactly SHOW_CYCLES cycles.
    localparam logic [SHOW_W-1:0]  SHOW_LOAD = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] DRAW_MAX  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [SHOW_W-1:0]  TIMER_ONE = SHOW_W'(1);

    typedef enum logic [1:0] {
        ST_READY      = 2'd0,
        ST_SHOW       = 2'd1,
        ST_MATCH_OVER = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SHOW_W-1:0]    r_timer;
    logic [SHOW_W-1:0]    w_timer_nxt;
    logic [2:0]           r_result_led;
    logic [2:0]           w_result_led_nxt;
    logic [SCORE_W-1:0]   r_p1_score;
    logic [SCORE_W-1:0]   w_p1_score_nxt;
    logic [SCORE_W-1:0]   r_p2_score;
    logic [SCORE_W-1:0]   w_p2_score_nxt;
    logic [SCORE_W-1:0]   r_draws;
    logic [SCORE_W-1:0]   w_draws_nxt;
    logic                 r_match_over;
    logic                 r_busy;
    logic                 r_invalid_round;
    logic                 w_invalid_nxt;
    logic                 w_p1_won;
    logic                 w_p2_won;

    // Match is decided by the registered scores, which already include the round being shown.
    always_comb begin
        w_p1_won = (r_p1_score == WIN_SCORE);
        w_p2_won = (r_p2_score == WIN_SCORE);
    end

    // Next-state and next-output logic; new_match overrides everything else.
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_result_led_nxt = r_result_led;
        w_p1_score_nxt   = r_p1_score;
        w_p2_score_nxt   = r_p2_score;
        w_draws_nxt      = r_draws;
        w_invalid_nxt    = 1'b0;

        if (i_new_match) begin
            w_state_nxt      = ST_READY;
            w_timer_nxt      = '0;
            w_result_led_nxt = CODE_NONE;
            w_p1_score_nxt   = '0;
            w_p2_score_nxt   = '0;
            w_draws_nxt      = '0;
        end else begin
            case (r_state)
                ST_READY: begin
                    if (i_round_start) begin
                        case (i_winner_in)
                            CODE_P1: begin
                                w_state_nxt      = ST_SHOW;
                                w_timer_nxt      = SHOW_LOAD;
                                w_result_led_nxt = CODE_P1;
                                w_p1_score_nxt   = r_p1_score + SCORE_ONE;
                            end
                            CODE_P2: begin
                                w_state_nxt      = ST_SHOW;
                                w_timer_nxt      = SHOW_LOAD;
                                w_result_led_nxt = CODE_P2;
                                w_p2_score_nxt   = r_p2_score + SCORE_ONE;
                            end
                            CODE_DRAW: begin
                                w_state_nxt      = ST_SHOW;
                                w_timer_nxt      = SHOW_LOAD;
                                w_result_led_nxt = CODE_DRAW;
                                // Draws never end a match, so the counter saturates instead of wrapping.
                                if (r_draws != DRAW_MAX) begin
                                    w_draws_nxt = r_draws + SCORE_ONE;
                                end
                            end
                            default: begin
                                // No judge result or a multi-hot glitch: flag it, change nothing else.
                                w_invalid_nxt = 1'b1;
                            end
                        endcase
                    end
                end

                ST_SHOW: begin
                    if (r_timer == '0) begin
                        if (w_p1_won) begin
                            w_state_nxt      = ST_MATCH_OVER;
                            w_result_led_nxt = CODE_P1;
                        end else if (w_p2_won) begin
                            w_state_nxt      = ST_MATCH_OVER;
                            w_result_led_nxt = CODE_P2;
                        end else begin
                            w_state_nxt      = ST_READY;
                            w_result_led_nxt = CODE_NONE;
                        end
                    end else begin
                        w_timer_nxt = r_timer - TIMER_ONE;
                    end
                end

                ST_MATCH_OVER: begin
                    // Winner stays lit until new_match; round commits are ignored.
                    w_state_nxt = ST_MATCH_OVER;
                end

                default: begin
                    w_state_nxt      = ST_READY;
                    w_timer_nxt      = '0;
                    w_result_led_nxt = CODE_NONE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers; status flags follow the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer         <= '0;
            r_result_led    <= CODE_NONE;
            r_p1_score      <= '0;
            r_p2_score      <= '0;
            r_draws         <= '0;
            r_match_over    <= 1'b0;
            r_busy          <= 1'b0;
            r_invalid_round <= 1'b0;
        end else begin
            r_timer         <= w_timer_nxt;
            r_result_led    <= w_result_led_nxt;
            r_p1_score      <= w_p1_score_nxt;
            r_p2_score      <= w_p2_score_nxt;
            r_draws         <= w_draws_nxt;
            r_match_over    <= (w_state_nxt == ST_MATCH_OVER);
            r_busy          <= (w_state_nxt != ST_READY);
            r_invalid_round <= w_invalid_nxt;
        end
    end

    assign o_result_led    = r_result_led;
    assign o_p1_score      = r_p1_score;
    assign o_p2_score      = r_p2_score;
    assign o_draws         = r_draws;
    assign o_match_over    = r_match_over;
    assign o_busy          = r_busy;
    assign o_invalid_round = r_invalid_round;

endmodule
